vend_ctrl_param: RTL
====================

Name: vend_ctrl_param

Overview:
Parametrised multi-product vending controller. It is the successor to the fixed two-product, 45-cent coin FSM.
- Accumulates nickel/dime/quarter credit up to a configurable ceiling.
- Vends one of NUM_PROD products at a configurable price and tracks per-product stock.
- Returns change or a cancel refund as timed nickel pulses.
- Sits between the coin-slot/button debouncers and the dispenser/coin-return actuators.

Parameters:
NUM_PROD, 2, number of products (1..8)
PRICE, 45, product price in cents; multiple of 5; PRICE <= MAX_CREDIT
MAX_CREDIT, 65, highest credit accepted in cents; multiple of 5
CREDIT_W, 7, credit register width; 2^CREDIT_W > MAX_CREDIT
PULSE_CYCLES, 4, change pulse high time and low gap, in clocks (>=1)
STOCK_W, 4, per-product stock counter width
STOCK_INIT, 8, stock loaded at reset and on restock; < 2^STOCK_W

Ports:
CLK  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ni  in  1  nickel inserted, one-cycle pulse
di  in  1  dime inserted, one-cycle pulse
qu  in  1  quarter inserted, one-cycle pulse
sel  in  NUM_PROD  product select, one-cycle pulse per bit
cancel  in  1  refund request, one-cycle pulse
restock  in  1  reload all stock counters
give  out  NUM_PROD  dispense strobe, one-cycle pulse
change  out  1  one nickel returned per high pulse
coin_reject  out  1  coin bounced to return tray, one-cycle pulse
credit  out  CREDIT_W  current credit in cents
busy  out  1  high in VEND/CHG_HI/CHG_LO
sold_out  out  NUM_PROD  stock counter == 0, per product

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, credit=0, every stock=STOCK_INIT.
  - give, change, coin_reject, busy = 0; pulse counter = 0.
  - Takes effect immediately, including mid-vend or mid-change. Any pending change is lost.
- All outputs are registered.
- States: IDLE, VEND, CHG_HI, CHG_LO.
- IDLE, coin handling:
  - Coin priority qu > di > ni. One coin per cycle is evaluated; lower-priority coins asserted in the same cycle are dropped silently.
  - Sum is computed in CREDIT_W+1 bits.
  - If credit+value <= MAX_CREDIT: credit updates next cycle.
  - Otherwise: coin_reject=1 for one cycle and credit is unchanged.
- IDLE, selection:
  - A sel bit is valid if credit >= PRICE and stock[i] != 0. The lowest valid index wins.
  - Valid select -> VEND next cycle. A valid sel outranks a coin and cancel in the same cycle; that coin gets coin_reject.
  - Invalid select (insufficient credit or sold out) is ignored, with no output.
- IDLE, cancel (no valid sel): credit > 0 -> CHG_HI; credit == 0 -> no-op.
- IDLE, restock: every stock reloads to STOCK_INIT. restock in any other state is ignored.
- VEND (exactly 1 cycle):
  - give[i]=1, credit -= PRICE, stock[i] -= 1.
  - Next state: CHG_HI if the remaining credit > 0, else IDLE.
- CHG_HI:
  - change=1 for PULSE_CYCLES cycles.
  - On the last high cycle, credit -= 5, then -> CHG_LO.
- CHG_LO:
  - change=0 for PULSE_CYCLES cycles.
  - Then -> CHG_HI if credit > 0, else IDLE.
  - Change is always paid in nickels: credit/5 pulses.
- Coins while busy: coin_reject=1 one cycle after the coin, credit unchanged. sel and cancel while busy are ignored.
- Latency:
  - give asserts on the cycle after the sampled sel.
  - First change high is the cycle after VEND.
  - credit reflects an accepted coin 1 cycle after the pulse.
- sold_out[i] is combinational from the registered stock (stock[i]==0). Stock never underflows.
- busy = (state != IDLE).

Test Plan (defaults unless stated):
1. qu, di, di on separate cycles, then sel=01 -> credit 25/35/45; give[0] high exactly 1 cycle; credit 0; no change pulses; stock[0]=7.
2. qu, qu, di (60), then sel=10 -> give[1] pulse, credit 15; then 3 change pulses, each 4 high/4 low; credit 10, 5, 0; return to IDLE with busy=0.
3. qu, qu (50), then qu -> coin_reject one cycle, credit stays 50. Also qu+ni in the same cycle at credit 0 -> credit 25 only.
4. Insert 35, then cancel -> 7 change pulses, credit 0. Also sel=11 at credit 45 -> give=01 only. Also a coin during CHG_HI -> coin_reject, credit unaffected.
5. STOCK_INIT=1: vend product 0 -> sold_out=01. Then at credit 45, sel=01 -> no give, credit stays 45. Then restock -> sold_out=00, and sel=01 vends.
6. Reset mid-change (rst low during the 2nd CHG_HI at credit 10) -> change=0 and credit=0 asynchronously; after release, state IDLE and stock=STOCK_INIT.

Source files
------------

// File: rtl/vend_ctrl_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vend_ctrl_param
// Parametrised multi-product vending controller. Accumulates nickel/dime/quarter
// credit up to MAX_CREDIT, vends one of NUM_PROD products at PRICE, tracks
// per-product stock and pays change or cancel refunds as timed nickel pulses.
//
// Ports:
//   CLK         rising-edge clock
//   rst         asynchronous active-low reset
//   ni/di/qu    coin inserted (nickel/dime/quarter), one-cycle pulses
//   sel         product select, one-cycle pulse per bit
//   cancel      refund request, one-cycle pulse
//   restock     reload every stock counter to STOCK_INIT (honoured in IDLE)
//   give        dispense strobe, one-cycle one-hot pulse
//   change      one nickel returned per high pulse
//   coin_reject coin bounced to the return tray, one-cycle pulse
//   credit      current credit in cents
//   busy        high while vending or paying change
//   sold_out    per-product stock counter is zero
// -----------------------------------------------------------------------------
module vend_ctrl_param #(
  parameter int NUM_PROD     = 2,
  parameter int PRICE        = 45,
  parameter int MAX_CREDIT   = 65,
  parameter int CREDIT_W     = 7,
  parameter int PULSE_CYCLES = 4,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 8
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                ni,
  input  logic                di,
  input  logic                qu,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                cancel,
  input  logic                restock,
  output logic [NUM_PROD-1:0] give,
  output logic                change,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [NUM_PROD-1:0] sold_out
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
  localparam logic [STOCK_W-1:0]  STOCK_C  = STOCK_W'(STOCK_INIT);
  localparam logic [CNT_W-1:0]    LAST_C   = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, VEND, CHG_HI, CHG_LO} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CREDIT_W-1:0]  credit_nxt;
  logic [NUM_PROD-1:0]  give_nxt;
  logic                 reject_nxt;
  logic                 restock_en;
  logic                 vend_dec;
  logic [STOCK_W-1:0]   stock [NUM_PROD];

  // Coin decode: highest-value coin wins, the rest are dropped.
  logic [SUM_W-1:0]     coin_val;
  logic [SUM_W-1:0]     credit_sum;
  logic                 has_coin;
  logic                 coin_fits;
  logic                 credit_ok;
  logic [NUM_PROD-1:0]  sel_ok;
  logic [NUM_PROD-1:0]  sel_win;
  logic                 pulse_last;

  always_comb begin
    if (qu)      coin_val = SUM_W'(25);
    else if (di) coin_val = SUM_W'(10);
    else if (ni) coin_val = SUM_W'(5);
    else         coin_val = '0;
  end

  assign has_coin   = qu | di | ni;
  assign credit_sum = {1'b0, credit} + coin_val;
  assign coin_fits  = (credit_sum <= SUM_W'(MAX_CREDIT));
  assign credit_ok  = ({1'b0, credit} >= SUM_W'(PRICE));
  assign pulse_last = (cnt == LAST_C);

  always_comb begin
    sel_ok   = '0;
    sold_out = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      sel_ok[i]   = sel[i] & credit_ok & (stock[i] != '0);
      sold_out[i] = (stock[i] == '0);
    end
  end

  // Isolate the lowest set bit so only one product can be chosen.
  assign sel_win = sel_ok & (~sel_ok + NUM_PROD'(1));

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    cnt_nxt    = cnt;
    give_nxt   = '0;
    reject_nxt = 1'b0;
    restock_en = 1'b0;
    vend_dec   = 1'b0;
    case (state)
      IDLE: begin
        restock_en = restock;
        if (|sel_win) begin
          state_nxt  = VEND;
          give_nxt   = sel_win;
          reject_nxt = has_coin;
        end else begin
          if (has_coin) begin
            if (coin_fits) credit_nxt = credit_sum[CREDIT_W-1:0];
            else           reject_nxt = 1'b1;
          end
          if (cancel && (credit != '0)) begin
            state_nxt = CHG_HI;
            cnt_nxt   = '0;
          end
        end
      end
      VEND: begin
        reject_nxt = has_coin;
        vend_dec   = 1'b1;
        credit_nxt = credit - PRICE_C;
        cnt_nxt    = '0;
        state_nxt  = (credit != PRICE_C) ? CHG_HI : IDLE;
      end
      CHG_HI: begin
        reject_nxt = has_coin;
        if (pulse_last) begin
          credit_nxt = credit - NICKEL_C;
          cnt_nxt    = '0;
          state_nxt  = CHG_LO;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      CHG_LO: begin
        reject_nxt = has_coin;
        if (pulse_last) begin
          cnt_nxt   = '0;
          state_nxt = (credit != '0) ? CHG_HI : IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      credit      <= '0;
      give        <= '0;
      change      <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      credit      <= credit_nxt;
      give        <= give_nxt;
      change      <= (state_nxt == CHG_HI);
      coin_reject <= reject_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  // NOTE: the stock array is reset on purpose: reset must reload every counter,
  // so it is a bank of flops, not a RAM.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_C;
    end else begin
      for (int i = 0; i < NUM_PROD; i++) begin
        if (restock_en)
          stock[i] <= STOCK_C;
        else if (vend_dec && give[i] && (stock[i] != '0))
          stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

endmodule
